// File: rtl/serial_subtractor4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_arith_pkg
// Brief    : Shared types, constants and a bit-level helper for the serial
//            arithmetic blocks (state encoding, default width, full_sub).
// Revision : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Explicit 2-bit encoding keeps the state register width fixed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-bit full subtraction x - y - bi, returned as {diff, bo}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic diff;
        logic bo;
        diff = x ^ y ^ bi;
        bo   = (~x & y) | (~(x ^ y) & bi);
        return {diff, bo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor4_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor4_if
// Brief    : Start/done handshake and operand/result bus of the serial
//            subtractor. master = requester, slave = subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor4_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor4_cell.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor_cell
// Brief    : One-bit full subtractor (x - y - bi) built only from two-input
//            NAND gates, mirroring the gate style of the ripple NAND adder.
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor_cell (
    input  wire logic x,
    input  wire logic y,
    input  wire logic bi,
    output logic      diff,
    output logic      bo
);
    // x XOR y from four NANDs
    logic w_n1, w_n2, w_n3, w_xy;
    // (x XOR y) XOR bi from four NANDs
    logic w_m1, w_m2, w_m3;
    // borrow terms
    logic w_nx, w_p, w_nxy, w_q;

    assign w_n1  = ~(x & y);
    assign w_n2  = ~(x & w_n1);
    assign w_n3  = ~(y & w_n1);
    assign w_xy  = ~(w_n2 & w_n3);

    assign w_m1  = ~(w_xy & bi);
    assign w_m2  = ~(w_xy & w_m1);
    assign w_m3  = ~(bi & w_m1);
    assign diff  = ~(w_m2 & w_m3);

    // bo = (~x & y) | (~(x^y) & bi), as NAND of the two inverted product terms
    assign w_nx  = ~(x & x);
    assign w_p   = ~(w_nx & y);
    assign w_nxy = ~(w_xy & w_xy);
    assign w_q   = ~(w_nxy & bi);
    assign bo    = ~(w_p & w_q);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor4.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor4
// Brief    : Bit-serial two's-complement subtractor d = a - b - bin, LSB
//            first over WIDTH cycles, one shared full-subtractor cell,
//            start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor4
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            rst,
    serial_subtractor4_if.slave  bus
);
    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-2:0]   r_res;   // diffs collected so far, newest at MSB
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_busy;
    logic               r_done;

    logic               w_diff;
    logic               w_bo;
    logic [WIDTH-1:0]   w_cat;   // result register after this edge's shift

    full_subtractor_cell u_cell (
        .x    (r_sa[0]),
        .y    (r_sb[0]),
        .bi   (r_br),
        .diff (w_diff),
        .bo   (w_bo)
    );

    // The dropped LSB of w_cat is only needed on the final edge, where the
    // whole vector becomes d; the stored part keeps WIDTH-1 bits.
    assign w_cat = {w_diff, r_res};

    // FSM, operand shift registers, borrow flop, counter and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_bo;
                    r_res <= w_cat[WIDTH-1:1];
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_d     <= w_cat;
                        r_bout  <= w_bo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.d    = r_d;
    assign bus.bout = r_bout;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor4.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor4
// Brief    : Self-checking bench for serial_subtractor4: directed corner
//            cases, handshake, reset, exhaustive and random operands against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor4;
    import serial_arith_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_subtractor4_if #(.WIDTH(W)) ifc ();

    serial_subtractor4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction; borrow out means the true result is negative.
    function automatic logic [W:0] ref_sub(input int a, input int b, input int bin);
        int         r;
        logic [W:0] res;
        r            = a - b - bin;
        res[W]       = (r < 0);
        res[W-1:0]   = W'(r);
        return res;
    endfunction

    // Waits (bounded) for a done pulse; returns negedges waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.done && n < 16);
    endtask

    // Counts done pulses over a fixed window.
    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ifc.done) nd++;
        end
    endtask

    task automatic run_op(input int a, input int b, input int bin, input string tag);
        logic [W:0] e;
        int         n, nb, ov;
        bit         got;
        e = ref_sub(a, b, bin);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.a     = W'(a);
        ifc.b     = W'(b);
        ifc.bin   = 1'(bin);
        n = 0; nb = 0; ov = 0; got = 0;
        while (!got && n < 16) begin
            @(negedge clk);
            ifc.start = 1'b0;
            n++;
            if (ifc.done && ifc.busy) ov++;
            if (ifc.done) got = 1;
            else if (ifc.busy) nb++;
        end
        chk({tag, "_lat"},     32'(n),  32'(W + 1));
        chk({tag, "_busy"},    32'(nb), 32'(W));
        chk({tag, "_overlap"}, 32'(ov), 32'd0);
        chk({tag, "_d"},       32'(ifc.d),    32'(e[W-1:0]));
        chk({tag, "_bout"},    32'(ifc.bout), 32'(e[W]));
    endtask

    initial begin
        int         n, nd;
        logic [W:0] e;
        int         ea, eb, ebin;

        rst = 1'b1;
        ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_d",    32'(ifc.d),    32'd0);
        chk("rst_bout", 32'(ifc.bout), 32'd0);
        rst = 1'b0;

        // Directed corner cases
        run_op(5, 3, 0, "basic");
        run_op(3, 5, 0, "underflow");
        run_op(0, 0, 1, "bin_only");
        run_op(15, 15, 0, "max_eq");
        run_op(15, 0, 0, "max_zero");

        // Reset mid-operation: abandoned, outputs cleared, no done
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 4'd7; ifc.b = 4'd1; ifc.bin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        chk("midrst_run1_busy", 32'(ifc.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(ifc.busy), 32'd0);
        chk("midrst_d",    32'(ifc.d),    32'd0);
        chk("midrst_bout", 32'(ifc.bout), 32'd0);
        count_done(10, nd);
        chk("midrst_nodone", 32'(nd), 32'd0);
        run_op(8, 8, 0, "after_rst");

        // start held high; operands change mid-RUN; back-to-back acceptance in DONE
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 4'd9; ifc.b = 4'd4; ifc.bin = 1'b0;
        @(negedge clk);
        ifc.a = 4'd2; ifc.b = 4'd1;
        wait_done(n);
        chk("held1_lat",  32'(n + 1),      32'(W + 1));
        chk("held1_d",    32'(ifc.d),      32'd5);
        chk("held1_bout", 32'(ifc.bout),   32'd0);
        wait_done(n);
        ifc.start = 1'b0;
        chk("held2_lat",  32'(n),          32'(W + 1));
        chk("held2_d",    32'(ifc.d),      32'd1);
        chk("held2_bout", 32'(ifc.bout),   32'd0);
        count_done(8, nd);
        chk("held_tail_nodone", 32'(nd), 32'd0);

        // start pulse while busy is ignored and not queued
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 4'd6; ifc.b = 4'd2; ifc.bin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 4'd15; ifc.b = 4'd0;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(n);
        chk("ignore_lat",  32'(n + 3),    32'(W + 1));
        chk("ignore_d",    32'(ifc.d),    32'd4);
        chk("ignore_bout", 32'(ifc.bout), 32'd0);
        count_done(8, nd);
        chk("ignore_nodone", 32'(nd), 32'd0);

        // rst together with start: start dropped, outputs cleared
        @(negedge clk);
        rst = 1'b1; ifc.start = 1'b1; ifc.a = 4'd3; ifc.b = 4'd1;
        @(negedge clk);
        rst = 1'b0; ifc.start = 1'b0;
        chk("rst_start_busy", 32'(ifc.busy), 32'd0);
        chk("rst_start_d",    32'(ifc.d),    32'd0);
        count_done(8, nd);
        chk("rst_start_nodone", 32'(nd), 32'd0);

        // Exhaustive back-to-back: next operands presented in each DONE cycle
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = '0; ifc.b = '0; ifc.bin = 1'b0;
        for (int i = 0; i < 512; i++) begin
            ea = (i >> 5) & 15; eb = (i >> 1) & 15; ebin = i & 1;
            e  = ref_sub(ea, eb, ebin);
            wait_done(n);
            chk($sformatf("exh%0d_lat", i),  32'(n),        32'(W + 1));
            chk($sformatf("exh%0d_d", i),    32'(ifc.d),    32'(e[W-1:0]));
            chk($sformatf("exh%0d_bout", i), 32'(ifc.bout), 32'(e[W]));
            if (i < 511) begin
                ifc.a   = W'(((i + 1) >> 5) & 15);
                ifc.b   = W'(((i + 1) >> 1) & 15);
                ifc.bin = 1'((i + 1) & 1);
            end else begin
                ifc.start = 1'b0;
            end
        end

        // Random operands with random idle gaps
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)), $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
